// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spart_pkg
// Purpose  : Shared types and constants for the SPART transmit-side controller.
//            - state_t        : transmit controller FSM states
//            - DIV_W          : divisor register width
//            - LAUNCH_TIMEOUT : cycles tbr may stay high after tx_begin
//                               before the launch is treated as lost
//            - TMO_W          : width of the launch timeout counter
// Revision : 1.0  initial release
// ============================================================================
package spart_pkg;

  localparam int DIV_W          = 16;
  localparam int LAUNCH_TIMEOUT = 4;
  localparam int TMO_W          = $clog2(LAUNCH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spart_tx_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches req starting one slot
//            after ptr, wrapping modulo NUM_REQ, and returns the first set
//            requester as a one-hot grant and as an index.
// Ports    : req    [NUM_REQ-1:0] in  - per-requester valid
//            ptr    [PTR_W-1:0]   in  - last granted requester
//            gnt_oh [NUM_REQ-1:0] out - one-hot pick (zero if no req)
//            idx    [PTR_W-1:0]   out - index of the pick
//            valid                out - at least one requester set
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  logic [PTR_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[w_cand]) begin
        gnt_oh         = '0;
        gnt_oh[w_cand] = 1'b1;
        idx            = w_cand;
        valid          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : spart_tx_arb
// Purpose  : Transmit-side controller for the SPART transmitter. Shares the
//            transmitter between NUM_REQ byte sources (round-robin), owns the
//            divisor register and sequences tx_begin against tbr.
// Ports    : clk, rst                         - clock, sync active-high reset
//            req[NUM_REQ], req_data[8*NUM_REQ]- requests and their bytes
//            gnt[NUM_REQ]                     - one-cycle accept pulse
//            div_wr, div_data[16]             - divisor write request
//            tbr                              - transmitter ready
//            tx_begin                         - one-cycle start pulse
//            transmit_buffer[8]               - byte held for the frame
//            divisor_buffer[16]               - active divisor
//            busy                             - FSM not in IDLE
//            div_pend                         - divisor write awaiting apply
// Revision : 1.0  initial release
// ============================================================================
module spart_tx_arb
  import spart_pkg::*;
#(
  parameter int               NUM_REQ     = 2,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd325
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic                 div_wr,
  input  logic [DIV_W-1:0]     div_data,
  input  logic                 tbr,
  output logic                 tx_begin,
  output logic [7:0]           transmit_buffer,
  output logic [DIV_W-1:0]     divisor_buffer,
  output logic                 busy,
  output logic                 div_pend
);

  localparam int               PTR_W      = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] C_RR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(LAUNCH_TIMEOUT - 1);

  state_t           state_q,    state_d;
  logic [PTR_W-1:0] rr_q,       rr_d;
  logic [TMO_W-1:0] tmo_q,      tmo_d;
  logic [7:0]       txbuf_q,    txbuf_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q,     pend_d;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic [NUM_REQ-1:0] w_gnt;
  logic [7:0]         w_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_q),
    .gnt_oh (w_arb_gnt),
    .idx    (w_arb_idx),
    .valid  (w_arb_valid)
  );

  // Byte of the winning requester, selected by the one-hot grant.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    tmo_d      = tmo_q;
    txbuf_d    = txbuf_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    w_gnt      = '0;

    case (state_q)
      IDLE: begin
        if (tbr) begin
          // A pending divisor is applied before any grant so the next frame
          // always goes out at the newly requested rate.
          if (pend_q) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
          end else if (w_arb_valid) begin
            w_gnt   = w_arb_gnt;
            txbuf_d = w_byte;
            rr_d    = w_arb_idx;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tbr) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == C_TMO_LAST) begin
          // Transmitter never took the byte; drop it and recover.
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tbr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write in the same cycle as an apply stays pending: last write wins.
    if (div_wr) begin
      pend_val_d = div_data;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= C_RR_RESET;
      tmo_q      <= '0;
      txbuf_q    <= 8'h00;
      div_q      <= DEFAULT_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      tmo_q      <= tmo_d;
      txbuf_q    <= txbuf_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  // Pulses are masked during reset so nothing is issued while rst is high.
  assign gnt             = w_gnt & {NUM_REQ{~rst}};
  assign tx_begin        = (state_q == LAUNCH) & ~rst;
  assign transmit_buffer = txbuf_q;
  assign divisor_buffer  = div_q;
  assign busy            = (state_q != IDLE);
  assign div_pend        = pend_q;

endmodule
`default_nettype wire

// File: doc/spart_tx_arb.md
Name: spart_tx_arb

Overview:
Transmit-side controller for the SPART transmitter. It shares the single transmitter between NUM_REQ byte sources using round-robin arbitration, owns the divisor configuration register, and sequences tx_begin against the transmitter's tbr handshake. It sits between the request sources (bus interface, echo path) and the transmitter's tx_begin, transmit_buffer and divisor_buffer inputs.

Parameters:
NUM_REQ, 2, number of byte requesters (2..4)
DEFAULT_DIV, 16'd325, divisor_buffer value loaded on reset

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
req  input  NUM_REQ  per-requester valid; held with data until granted
req_data  input  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i]
gnt  output  NUM_REQ  one-cycle accept pulse, one-hot or zero
div_wr  input  1  request to load new divisor
div_data  input  16  new divisor value
tbr  input  1  transmitter ready (high when transmitter idle)
tx_begin  output  1  one-cycle start pulse to transmitter
transmit_buffer  output  8  byte to transmitter; held stable from launch to end of frame
divisor_buffer  output  16  active divisor to transmitter
busy  output  1  high in any state except IDLE
div_pend  output  1  divisor write accepted but not yet applied

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; gnt=0; tx_begin=0; transmit_buffer=8'h00; divisor_buffer=DEFAULT_DIV; div_pend=0; rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- Divisor writes: div_wr is accepted in any cycle. div_data goes to a pending register and div_pend is set. A later div_wr before the update is applied overwrites the pending value (last write wins).
- Divisor apply: in IDLE with tbr=1 and div_pend=1, divisor_buffer<=pending and div_pend<=0. No grant is issued that cycle; the divisor update takes priority over requests. divisor_buffer never changes outside IDLE.
- Grant: in IDLE with tbr=1, div_pend=0 and req!=0:
  - Pick the first set req after the rr pointer, wrapping around.
  - Pulse gnt[i] that cycle; transmit_buffer<=req_data[i]; rr pointer<=i; next state LAUNCH.
  - Requester i must drop or update req in the cycle after gnt.
- IDLE with tbr=0: no grant; remain in IDLE. This covers a transmitter still busy after reset.
- LAUNCH: tx_begin=1 for exactly this cycle; next state WAIT_BUSY.
- WAIT_BUSY: wait for tbr=0. If tbr is still 1 for 4 consecutive cycles, return to IDLE (launch lost; byte dropped). Otherwise go to WAIT_DONE.
- WAIT_DONE: wait for tbr=1, then go to IDLE.
- Latency: gnt to tx_begin is 1 cycle. Back-to-back frames are separated by at least one IDLE cycle after tbr rises.
- gnt and tx_begin are never asserted in the same cycle. There is at most one byte in flight.
- A new req during LAUNCH, WAIT_BUSY or WAIT_DONE is held off; it is not lost, because requesters hold req.
- Reset mid-frame: the controller returns to IDLE immediately and drops the pending divisor. The transmitter's own reset is responsible for the line.
- rr pointer width is clog2(NUM_REQ). Wrap-around uses modulo NUM_REQ arithmetic; no out-of-range index is produced.

Decomposition:
- Package spart_pkg: state enum type (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE); constant DIV_W=16; constant LAUNCH_TIMEOUT=4.
- One sub-module, rr_arbiter: combinational round-robin pick from req and pointer, giving a one-hot grant and an index.
- FSM, hold register, divisor registers and timeout counter stay in spart_tx_arb.

Test Plan:
- Reset, then req=2'b01 with byte 8'hA5, tbr=1 -> gnt=2'b01 in cycle 0, tx_begin=1 in cycle 1, transmit_buffer=8'hA5; with the transmitter model, tbr=0 in cycle 2; busy stays high until tbr returns to 1.
- req=2'b11 held continuously (8'h11 / 8'h22) -> grant order 0,1,0,1; no requester is granted twice in a row; exactly one tx_begin per frame.
- div_wr with 16'd2 during WAIT_DONE -> div_pend=1 and divisor_buffer unchanged until the frame ends. Then one IDLE cycle applies 16'd2 with no gnt, and the next grant follows.
- Two div_wr (16'd100, then 16'd7) before apply -> divisor_buffer becomes 16'd7 only.
- Transmitter model ignores tx_begin (tbr stays 1) -> return to IDLE after 4 WAIT_BUSY cycles; next req is granted normally.
- rst=1 asserted in WAIT_DONE with div_pend=1 -> next cycle: state IDLE, gnt=0, tx_begin=0, divisor_buffer=DEFAULT_DIV, div_pend=0.
